// File: rtl/mem_line_responder_if.sv
// Request/response bundle between a cache's line-fill/write-back port and main memory.
// "master" is the cache side, "slave" is the memory responder.
interface mem_line_responder_if #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 128,
  parameter int BEAT_W = 32
);
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_line;
  logic [LINE_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [BEAT_W-1:0]     resp_data;
  logic [BEAT_IDX_W-1:0] resp_beat;
  logic                  resp_last;
  logic                  wr_ack;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_line, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_beat, resp_last, wr_ack, busy
  );

  modport slave (
    input  req_valid, req_write, req_line, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_beat, resp_last, wr_ack, busy
  );
endinterface

// File: rtl/mem_line_responder.sv
// Main-memory model for cache line fills and write-backs: fixed access latency,
// then a backpressured beat stream for reads or a one-cycle ack for writes.
module mem_line_responder #(
  parameter int ADDR_W  = 8,
  parameter int LINE_W  = 128,
  parameter int BEAT_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_line_responder_if.slave   bus
);
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SEND, ACK} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;

  logic [ADDR_W-1:0]     line_q;
  logic                  wr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     buf_q;
  logic [LINE_W-1:0]     mem_q [2**ADDR_W];

  logic                  accept;
  logic                  commit;
  logic                  fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    accept  = 1'b0;
    commit  = 1'b0;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (wr_q) begin
            commit  = 1'b1;
            state_d = ACK;
          end else begin
            fill    = 1'b1;
            beat_d  = '0;
            state_d = SEND;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEND: begin
        if (bus.resp_ready) begin
          if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array and request copies are plain storage: reset only has to stop new
  // commits, which it does by forcing the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q  <= bus.req_line;
      wr_q    <= bus.req_write;
      wdata_q <= bus.req_wdata;
    end
    if (commit) begin
      mem_q[line_q] <= wdata_q;
    end
    if (fill) begin
      buf_q <= mem_q[line_q];
    end
  end

  assign bus.req_ready  = rst_n && (state_q == IDLE);
  assign bus.resp_valid = (state_q == SEND);
  assign bus.resp_data  = (state_q == SEND) ? buf_q[beat_q*BEAT_W +: BEAT_W] : '0;
  assign bus.resp_beat  = beat_q;
  assign bus.resp_last  = (state_q == SEND) && (beat_q == BEAT_IDX_W'(BEATS - 1));
  assign bus.wr_ack     = (state_q == ACK);
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: reset, write/read, backpressure,
// busy rejection, reset during a write and back-to-back reads.
module tb_mem_line_responder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_line_responder_if bus ();

  mem_line_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns 1ns after the edge that accepted it.
  task automatic applyStimulus(input logic wr, input logic [7:0] line, input logic [127:0] wdata,
                               output int waits);
    waits = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_line  = line;
    bus.req_wdata = wdata;
    while (!bus.req_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!bus.req_ready) checkOutput("acceptTimeout", 1'b0, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = '0;
  endtask

  task automatic writeLine(input logic [7:0] line, input logic [127:0] data);
    int waits;
    applyStimulus(1'b1, line, data, waits);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("wrAckTiming", bus.wr_ack, (k == 4));
    end
  endtask

  // Collects one read starting startEdge edges after acceptance; stall drops
  // resp_ready for that many cycles while beat 1 is presented.
  task automatic collectRead(input logic [127:0] expLine, input int stall, input int startEdge,
                             output int edges);
    edges = startEdge;
    bus.resp_ready = 1'b1;
    while (edges < 3) begin
      tick();
      edges++;
    end
    checkOutput("noEarlyValid", bus.resp_valid, 1'b0);
    tick();
    edges++;
    for (int b = 0; b < 4; b++) begin
      checkOutput("respValid", bus.resp_valid, 1'b1);
      checkOutput("respBeat", bus.resp_beat, b);
      checkOutput("respData", bus.resp_data, expLine[32*b +: 32]);
      checkOutput("respLast", bus.resp_last, (b == 3));
      if (b == 1 && stall > 0) begin
        bus.resp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          edges++;
          checkOutput("stallData", bus.resp_data, expLine[63:32]);
          checkOutput("stallBeat", bus.resp_beat, 1);
        end
        bus.resp_ready = 1'b1;
      end
      tick();
      edges++;
    end
    checkOutput("readyAfterLast", bus.req_ready, 1'b1);
    checkOutput("validAfterLast", bus.resp_valid, 1'b0);
  endtask

  localparam logic [127:0] LINE_FF = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_01 = 128'h0101ABCD_0202BCDE_0303CDEF_0404DEF0;
  localparam logic [127:0] LINE_00 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;

  initial begin
    int waits;
    int edges;
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_line   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) tick();
    checkOutput("rstReqReady", bus.req_ready, 1'b0);
    checkOutput("rstRespValid", bus.resp_valid, 1'b0);
    checkOutput("rstRespData", bus.resp_data, 32'h0);
    checkOutput("rstRespBeat", bus.resp_beat, 2'd0);
    checkOutput("rstRespLast", bus.resp_last, 1'b0);
    checkOutput("rstWrAck", bus.wr_ack, 1'b0);
    checkOutput("rstBusy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("postRstReady", bus.req_ready, 1'b1);
    checkOutput("postRstBusy", bus.busy, 1'b0);

    writeLine(8'hFF, LINE_FF);
    applyStimulus(1'b0, 8'hFF, '0, waits);
    collectRead(LINE_FF, 0, 0, edges);
    checkOutput("readEdges", edges, 8);

    applyStimulus(1'b0, 8'hFF, '0, waits);
    collectRead(LINE_FF, 3, 0, edges);
    checkOutput("stallReadEdges", edges, 11);

    writeLine(8'h01, LINE_01);
    applyStimulus(1'b0, 8'h01, '0, waits);
    tick();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_line  = 8'h01;
    bus.req_wdata = {4{32'h5A5A5A5A}};
    checkOutput("busyReady1", bus.req_ready, 1'b0);
    tick();
    checkOutput("busyReady2", bus.req_ready, 1'b0);
    checkOutput("busyFlag", bus.busy, 1'b1);
    bus.req_valid = 1'b0;
    collectRead(LINE_01, 0, 2, edges);
    for (int k = 0; k < 3; k++) begin
      checkOutput("noWrAck", bus.wr_ack, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h01, '0, waits);
    collectRead(LINE_01, 0, 0, edges);

    writeLine(8'h10, '0);
    applyStimulus(1'b1, 8'h10, {16{8'hA5}}, waits);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", bus.req_ready, 1'b0);
    checkOutput("midRstBusy", bus.busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("noAckAfterRst", bus.wr_ack, 1'b0);
    end
    applyStimulus(1'b0, 8'h10, '0, waits);
    collectRead('0, 0, 0, edges);

    writeLine(8'h00, LINE_00);
    applyStimulus(1'b0, 8'h00, '0, waits);
    collectRead(LINE_00, 0, 0, edges);
    applyStimulus(1'b0, 8'hFF, '0, waits);
    checkOutput("b2bNoBubble", waits, 0);
    collectRead(LINE_FF, 0, 0, edges);
    checkOutput("b2bEdges", edges, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
